// File: rtl/hynoc_egress_sched.sv
// Wormhole round-robin scheduler for one hynoc egress port: grants one ingress
// requester per packet and releases on stop flit, request drop or idle watchdog.
module hynoc_egress_sched #(
  parameter int NB_PORTS        = 5,
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int AFULL_MARGIN    = 5,
  parameter int TIMEOUT_WIDTH   = 8,
  localparam int R              = NB_PORTS - 1,
  localparam int SEL_W          = (R > 1) ? $clog2(R) : 1
) (
  input  logic                       router_clk,
  input  logic                       router_arst,
  input  logic [R-1:0]               from_ingress_request,
  input  logic [R-1:0]               from_ingress_write,
  input  logic [R-1:0]               from_ingress_stop,
  input  logic [LOG2_FIFO_DEPTH:0]   wlevel,
  output logic [R-1:0]               to_ingress_grant,
  output logic [R-1:0]               to_ingress_afull,
  output logic [SEL_W-1:0]           sel,
  output logic                       inprocess,
  output logic                       timeout_pulse,
  output logic [15:0]                pkt_count
);

  // A non-positive threshold clamps to zero so afull is constant while granted.
  localparam int THR_INT = (1 << LOG2_FIFO_DEPTH) - AFULL_MARGIN;
  localparam logic [LOG2_FIFO_DEPTH:0] AFULL_THR =
    (THR_INT > 0) ? (LOG2_FIFO_DEPTH+1)'(THR_INT) : '0;
  localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX = '1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [SEL_W-1:0]         ptr_q, ptr_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [R-1:0]             grant_q, grant_d;
  logic [R-1:0]             afull_q, afull_d;
  logic                     inprocess_q, inprocess_d;
  logic                     timeout_pulse_q, timeout_pulse_d;
  logic [15:0]              pkt_count_q, pkt_count_d;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

  logic [SEL_W-1:0]         pick_idx, scan_idx, sel_inc;
  logic                     pick_vld;
  logic                     end_pkt, wd_hit, abort, release_pkt;

  // State register
  always_ff @(posedge router_clk or posedge router_arst) begin
    if (router_arst) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      sel_q           <= '0;
      grant_q         <= '0;
      afull_q         <= '0;
      inprocess_q     <= 1'b0;
      timeout_pulse_q <= 1'b0;
      pkt_count_q     <= '0;
      wd_cnt_q        <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      sel_q           <= sel_d;
      grant_q         <= grant_d;
      afull_q         <= afull_d;
      inprocess_q     <= inprocess_d;
      timeout_pulse_q <= timeout_pulse_d;
      pkt_count_q     <= pkt_count_d;
      wd_cnt_q        <= wd_cnt_d;
    end
  end

  // Cyclic first-set scan starting at the round-robin pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int i = 0; i < R; i++) begin
      scan_idx = SEL_W'((int'(ptr_q) + i) % R);
      if (!pick_vld && from_ingress_request[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
    sel_inc = SEL_W'((int'(sel_q) + 1) % R);
  end

  // Next-state logic; a stop write wins over watchdog and request drop.
  always_comb begin
    end_pkt     = from_ingress_write[sel_q] & from_ingress_stop[sel_q];
    wd_hit      = (wd_cnt_q == WD_MAX);
    abort       = ~from_ingress_request[sel_q];
    release_pkt = (state_q == BUSY) & (end_pkt | wd_hit | abort);
    state_d     = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = BUSY;
      BUSY:    if (release_pkt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath registers
  always_comb begin
    ptr_d           = ptr_q;
    sel_d           = sel_q;
    grant_d         = grant_q;
    pkt_count_d     = pkt_count_q;
    timeout_pulse_d = 1'b0;
    wd_cnt_d        = '0;
    if (state_q == IDLE) begin
      grant_d = '0;
      if (pick_vld) begin
        sel_d = pick_idx;
        for (int i = 0; i < R; i++) grant_d[i] = (SEL_W'(i) == pick_idx);
      end
    end else if (release_pkt) begin
      grant_d = '0;
      ptr_d   = sel_inc;
      if (end_pkt) pkt_count_d = pkt_count_q + 16'd1;
      else if (wd_hit) timeout_pulse_d = 1'b1;
    end else begin
      wd_cnt_d = from_ingress_write[sel_q] ? '0 : wd_cnt_q + 1'b1;
    end
    inprocess_d = (state_d == BUSY);
    afull_d     = grant_d & {R{wlevel >= AFULL_THR}};
  end

  assign to_ingress_grant = grant_q;
  assign to_ingress_afull = afull_q;
  assign sel              = sel_q;
  assign inprocess        = inprocess_q;
  assign timeout_pulse    = timeout_pulse_q;
  assign pkt_count        = pkt_count_q;

endmodule

// File: tb/tb_hynoc_egress_sched.sv
// Bench for hynoc_egress_sched: directed scenarios then random traffic, all
// cycles compared against a packet-level reference model.
module tb_hynoc_egress_sched;

  localparam int NB_PORTS = 5;
  localparam int R        = NB_PORTS - 1;
  localparam int L        = 5;
  localparam int MARGIN   = 5;
  localparam int TW       = 4;
  localparam int TMAX     = (1 << TW) - 1;
  localparam int THR      = (1 << L) - MARGIN;
  localparam int SEL_W    = 2;

  // Handshake: a requester holds request for its whole packet; a flit moves on
  // every cycle its write is high while granted, stop marks the last flit.
  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic [R-1:0]     req = '0;
  logic [R-1:0]     wr = '0;
  logic [R-1:0]     st = '0;
  logic [L:0]       wlevel = '0;
  logic [R-1:0]     grant, afull;
  logic [SEL_W-1:0] sel;
  logic             inprocess, timeout_pulse;
  logic [15:0]      pkt_count;

  hynoc_egress_sched #(
    .NB_PORTS(NB_PORTS), .LOG2_FIFO_DEPTH(L), .AFULL_MARGIN(MARGIN), .TIMEOUT_WIDTH(TW)
  ) dut (
    .router_clk(clk), .router_arst(arst),
    .from_ingress_request(req), .from_ingress_write(wr), .from_ingress_stop(st),
    .wlevel(wlevel),
    .to_ingress_grant(grant), .to_ingress_afull(afull), .sel(sel),
    .inprocess(inprocess), .timeout_pulse(timeout_pulse), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, where the next search starts,
  // how long the owner has been silent, how many packets completed.
  int           m_ptr, m_owner, m_idle, m_pkt, m_sel;
  logic [R-1:0] e_grant, e_afull;
  logic         e_inproc, e_to;
  logic [R-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_idle = 0; m_pkt = 0; m_sel = 0;
    e_grant = '0; e_afull = '0; e_inproc = 1'b0; e_to = 1'b0;
  endtask

  task automatic model_edge();
    int nxt;
    bit rel;
    logic [R-1:0] one;
    one = 1;
    if (arst) begin
      model_reset();
      return;
    end
    nxt = m_owner; rel = 0; e_to = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < R; i++)
        if (nxt < 0 && req[(m_ptr + i) % R]) nxt = (m_ptr + i) % R;
      if (nxt >= 0) begin m_sel = nxt; m_idle = 0; end
    end else if (wr[m_owner] && st[m_owner]) begin
      m_pkt = (m_pkt + 1) % 65536; rel = 1;
    end else if (m_idle == TMAX) begin
      e_to = 1'b1; rel = 1;
    end else if (!req[m_owner]) begin
      rel = 1;
    end else begin
      m_idle = wr[m_owner] ? 0 : m_idle + 1;
    end
    if (rel) begin m_ptr = (m_owner + 1) % R; nxt = -1; m_idle = 0; end
    m_owner  = nxt;
    e_grant  = (nxt >= 0) ? (one << nxt) : '0;
    e_inproc = (nxt >= 0);
    e_afull  = (int'(wlevel) >= THR) ? e_grant : '0;
  endtask

  task automatic check_all();
    check("grant", 32'(grant), 32'(e_grant));
    check("afull", 32'(afull), 32'(e_afull));
    check("sel", 32'(sel), 32'(m_sel));
    check("inprocess", 32'(inprocess), 32'(e_inproc));
    check("timeout_pulse", 32'(timeout_pulse), 32'(e_to));
    check("pkt_count", 32'(pkt_count), 32'(m_pkt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int           waited, n, own;
  bit           sparse;
  logic [R-1:0] g, one_r;

  initial begin
    one_r = 1;
    model_reset();
    step(); step();
    check("rst_grant", 32'(grant), 0);
    check("rst_pkt", 32'(pkt_count), 0);
    arst = 1'b0;

    // Single requester, 3-flit packet
    req = 4'b0001; step();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_sel", 32'(sel), 0);
    wr = 4'b0001; st = 4'b0000; step(); step();
    st = 4'b0001; step();
    check("t1_release", 32'(grant), 0);
    check("t1_pkt", 32'(pkt_count), 1);
    req = '0; wr = '0; st = '0; step();

    // All requesting, 2-flit packets, order from a fresh pointer
    arst = 1'b1; step(); arst = 1'b0;
    for (int p = 0; p < 5; p++) exp_q.push_back(one_r << (p % R));
    req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      waited = 0;
      while (grant === '0 && waited < 8) begin step(); waited++; end
      g = exp_q.pop_front();
      check("t2_gap", 32'(waited), 1);
      check("t2_order", 32'(grant), 32'(g));
      check("t2_sel", 32'(sel), 32'(p % R));
      wr = g; st = '0; step();
      st = g; step();
      wr = '0; st = '0;
    end
    req = '0; step();

    // Requester 2 single-flit packet, pointer moves to 3
    req = 4'b0100; step();
    check("t3_grant", 32'(grant), 32'h4);
    wr = 4'b0100; st = 4'b0100; step();
    check("t3_release", 32'(grant), 0);
    check("t3_pkt", 32'(pkt_count), 6);
    wr = '0; st = '0; req = 4'b1111; step();
    check("t3_ptr", 32'(grant), 32'h8);
    wr = 4'b1000; st = 4'b1000; step();
    wr = '0; st = '0; req = '0; step();

    // Watchdog: owner silent with request held
    req = 4'b0001; step();
    check("t4_grant", 32'(grant), 32'h1);
    n = 0;
    while (timeout_pulse !== 1'b1 && n < 40) begin step(); n++; end
    check("t4_wd_len", 32'(n), 16);
    check("t4_grant_rel", 32'(grant), 0);
    check("t4_pkt", 32'(pkt_count), 7);
    req = '0; step();
    check("t4_pulse_one", 32'(timeout_pulse), 0);

    // Almost-full threshold at 27
    wlevel = 26; req = 4'b0010; step();
    check("t5_grant", 32'(grant), 32'h2);
    check("t5_afull26", 32'(afull), 0);
    wlevel = 27; step();
    check("t5_afull27", 32'(afull), 32'h2);
    wr = 4'b0010; st = 4'b0010; req = '0; step();
    wr = '0; st = '0; wlevel = 31; step();
    check("t5_afull_nogrant", 32'(afull), 0);

    // Asynchronous reset in the middle of a packet
    req = 4'b0001; step();
    wr = 4'b0001; step();
    #2 arst = 1'b1;
    #1;
    check("t6_grant", 32'(grant), 0);
    check("t6_inproc", 32'(inprocess), 0);
    check("t6_pkt", 32'(pkt_count), 0);
    model_reset();
    wr = '0; req = '0; step();
    arst = 1'b0; req = 4'b1111; step();
    check("t6_restart", 32'(grant), 32'h1);
    wr = 4'b0001; st = 4'b0001; step();
    wr = '0; st = '0; req = '0; step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      sparse = ((c / 250) % 2) == 1;
      for (int k = 0; k < R; k++) begin
        if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
        wr[k] = ($urandom_range(0, 1) == 1);
        st[k] = ($urandom_range(0, 2) == 0);
      end
      own = m_owner;
      if (own >= 0) begin
        req[own] = ($urandom_range(0, 29) != 0);
        wr[own]  = sparse ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1);
        if (m_idle == TMAX) begin
          wr[own] = 1'b0;
          req[own] = 1'b1;
        end
      end
      wlevel = (L+1)'($urandom_range(20, 32));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hynoc_egress_sched.md
Name: hynoc_egress_sched

Overview:
- Packet-level (wormhole) round-robin scheduler for one hynoc egress port.
- Grants exactly one of the NB_PORTS-1 ingress requesters at a time and holds the grant until that requester's stop flit has been written.
- Drives per-requester grant and almost-full indications, plus the mux select and in-process flags that the egress datapath uses to steer flits into the output FIFO.
- Recovers from stalled or aborted packets with an idle-write watchdog.

Parameters:
- NB_PORTS, 5, ports in the router; requester count R = NB_PORTS-1.
- LOG2_FIFO_DEPTH, 5, log2 of the egress FIFO depth.
- AFULL_MARGIN, 5, almost-full asserted when wlevel >= 2**LOG2_FIFO_DEPTH - AFULL_MARGIN.
- TIMEOUT_WIDTH, 8, watchdog counter width; timeout at 2**TIMEOUT_WIDTH-1 idle cycles.
- Derived: SEL_W = max(1, clog2(R)).

Ports:
- router_clk  in  1  router clock.
- router_arst  in  1  asynchronous active-high reset.
- from_ingress_request  in  R  per-requester packet request.
- from_ingress_write  in  R  per-requester flit write strobe.
- from_ingress_stop  in  R  stop bit of each requester's current flit, valid with write.
- wlevel  in  LOG2_FIFO_DEPTH+1  egress FIFO fill level.
- to_ingress_grant  out  R  registered one-hot grant.
- to_ingress_afull  out  R  registered almost-full, gated by grant.
- sel  out  SEL_W  index of the granted requester, used as the datapath mux select.
- inprocess  out  1  high while a grant is held.
- timeout_pulse  out  1  one-cycle pulse on watchdog release.
- pkt_count  out  16  completed-packet counter, wraps modulo 2**16.

Behaviour:
- Reset (async, active-high): all outputs 0, round-robin pointer ptr=0, watchdog counter 0, state IDLE.
- Two states: IDLE and BUSY.
- IDLE arbitration:
  - If any request bit is set, select the first set index scanning cyclically from ptr.
  - At the next edge: to_ingress_grant = onehot(index), sel = index, inprocess = 1, state BUSY.
  - With no request, remain IDLE; grant, inprocess and afull stay 0, and sel holds its last value.
- BUSY, end of packet: a cycle with from_ingress_write[sel] & from_ingress_stop[sel] is the end cycle E.
  - At E+1: grant=0, inprocess=0, ptr=(sel+1) mod R, pkt_count+1, state IDLE.
  - The earliest new grant is at E+2.
- BUSY, abort: request[sel] low without a stop write causes release at the next edge with the same updates as end of packet, except pkt_count is unchanged. If stop write and request drop occur in the same cycle, the stop takes precedence and the packet is counted.
- Watchdog:
  - In BUSY, the counter increments each cycle write[sel]=0 and clears on write[sel]=1.
  - When it reaches 2**TIMEOUT_WIDTH-1: release at the next edge, timeout_pulse=1 for exactly that cycle, ptr advances, pkt_count unchanged.
  - The counter clears on entering IDLE.
- Single-flit packet: a stop write in the first BUSY cycle is a valid end cycle.
- Writes and stops from non-granted requesters are ignored.
- Almost-full: to_ingress_afull <= grant_next & {R{wlevel >= 2**LOG2_FIFO_DEPTH - AFULL_MARGIN}}, registered so it aligns with to_ingress_grant. It is 0 whenever the grant is 0.
- Comparison arithmetic is done at LOG2_FIFO_DEPTH+1 bits. A threshold that evaluates to a value <= 0 forces afull constantly while a grant is held.
- Grant is always one-hot or zero. The pointer wraps from R-1 to 0.
- Reset asserted mid-packet clears everything immediately (asynchronous); the partial packet is not counted.

Test Plan:
- Single requester: request[0], 3-flit packet with stop on flit 3 -> grant=0001 one cycle after request; grant drops at E+1; pkt_count=1; sel=0.
- All four requesting continuously, 2-flit packets -> grant order 0,1,2,3,0; sel 0,1,2,3,0; two-cycle gap from each stop flit to the next grant.
- Requester 2 sends a single-flit packet, stop on its first BUSY cycle -> release at E+1, ptr=3, pkt_count increments.
- Granted requester stops writing, request held, TIMEOUT_WIDTH=4 -> release after 15 idle cycles, timeout_pulse high one cycle, pkt_count unchanged.
- wlevel=26 then 27 (depth 32, margin 5) while requester 1 is granted -> afull=0000, then 0010 one cycle later; with no grant and wlevel=31, afull=0000.
- router_arst asserted mid-packet, between clock edges -> grant, inprocess and pkt_count 0 immediately; after reset deasserts, arbitration restarts from ptr=0.
